// File: rtl/pipe_if.sv
// pipe_if: instruction-fetch stage of the 5-stage MIPS pipeline.
// Owns the PC, picks the next PC (sequential, ID redirect, CP0 flush/eret),
// addresses a combinational instruction memory and offers pc/instr to ID.
//
// Handshake (valid/ready): IF presents if_id_validto together with pc_out and
// instr_out; ID takes them on any cycle where if_id_validto & id_allowin are
// both high ("accept"). While id_allowin is low the offered pc/instr hold.
module pipe_if #(
  parameter logic [31:0] RESET_PC   = 32'h0040_0000,
  parameter logic [31:0] EXC_VECTOR = 32'h0040_0004,
  parameter int          IMEM_AW    = 11
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               id_allowin,
  output logic               if_id_validto,
  output logic [31:0]        pc_out,
  output logic [31:0]        instr_out,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_rdata,
  input  logic               id_leave,
  input  logic [2:0]         npc_mux_sel,
  input  logic [31:0]        id_pc,
  input  logic [15:0]        id_imm,
  input  logic [25:0]        id_j_imm,
  input  logic [31:0]        id_rs,
  input  logic               cp0_flush,
  input  logic               eret_flush,
  input  logic [31:0]        cp0_epc,
  input  logic               cp0_hlt,
  output logic [31:0]        fetch_cnt,
  output logic [1:0]         state_o    // debug view of the fetch FSM
);

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        if_valid_q, if_valid_d;
  logic        pend_q, pend_d;
  logic [31:0] pend_pc_q, pend_pc_d;
  logic [31:0] fetch_cnt_q, fetch_cnt_d;

  logic        if_allowin;
  logic        accept;
  logic        redirect;
  logic [31:0] id_pc_4;
  logic [31:0] br_off;
  logic [31:0] target;
  logic [31:0] seq_pc;

  // IF never stalls internally (ready_go is constant 1), so the stage is
  // re-filled whenever it is empty or its current instruction is taken.
  assign if_allowin    = !if_valid_q | id_allowin;
  assign if_id_validto = if_valid_q & (state_q == S_RUN) & !cp0_flush & !eret_flush;
  assign accept        = if_id_validto & if_allowin;

  assign pc_out    = pc_q;
  assign instr_out = imem_rdata;
  assign imem_addr = pc_q[IMEM_AW+1:2];
  assign fetch_cnt = fetch_cnt_q;
  assign state_o   = state_q;

  assign seq_pc  = pc_q + 32'd4;
  assign id_pc_4 = id_pc + 32'd4;
  assign br_off  = {{14{id_imm[15]}}, id_imm, 2'b00};

  // Redirect target chosen by ID; selects 4-7 are plain sequential fetch.
  always_comb begin
    target   = seq_pc;
    redirect = 1'b0;
    case (npc_mux_sel)
      3'd1: begin target = id_pc_4 + br_off;                  redirect = id_leave; end
      3'd2: begin target = {id_pc_4[31:28], id_j_imm, 2'b00}; redirect = id_leave; end
      3'd3: begin target = id_rs;                             redirect = id_leave; end
      default: ;
    endcase
  end

  // Next-state logic: FSM step, then flush/eret/halt/redirect/sequential priority.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    if_valid_d  = if_valid_q;
    pend_d      = pend_q;
    pend_pc_d   = pend_pc_q;
    fetch_cnt_d = fetch_cnt_q + {31'd0, accept};

    case (state_q)
      S_BOOT: begin
        state_d    = S_RUN;
        if_valid_d = 1'b1;
      end
      S_HALT:  if_valid_d = 1'b0;
      default: ;
    endcase

    if (state_q != S_HALT) begin
      if (cp0_flush) begin
        pc_d   = EXC_VECTOR;
        pend_d = 1'b0;
      end else if (eret_flush) begin
        pc_d   = cp0_epc;
        pend_d = 1'b0;
      end else if (cp0_hlt) begin
        state_d    = S_HALT;
        if_valid_d = 1'b0;
      end else if (accept) begin
        // The instruction leaving now is the delay slot when a redirect
        // arrives together with it, so the target is fetched next.
        if (redirect) begin
          pc_d   = target;
          pend_d = 1'b0;
        end else if (pend_q) begin
          pc_d   = pend_pc_q;
          pend_d = 1'b0;
        end else begin
          pc_d = seq_pc;
        end
      end else if (redirect) begin
        // Delay slot not yet handed over: park the target until it is.
        pend_d    = 1'b1;
        pend_pc_d = target;
      end
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_BOOT;
      pc_q        <= RESET_PC;
      if_valid_q  <= 1'b0;
      pend_q      <= 1'b0;
      pend_pc_q   <= 32'd0;
      fetch_cnt_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      if_valid_q  <= if_valid_d;
      pend_q      <= pend_d;
      pend_pc_q   <= pend_pc_d;
      fetch_cnt_q <= fetch_cnt_d;
    end
  end

endmodule

// File: tb/tb_pipe_if.sv
// tb_pipe_if: directed scenarios plus randomized traffic for pipe_if, checked
// against a behavioural fetch model (PC flow, pending redirect, counters).
module tb_pipe_if;

  localparam logic [31:0] RESET_PC   = 32'h0040_0000;
  localparam logic [31:0] EXC_VECTOR = 32'h0040_0004;
  localparam int          IMEM_AW    = 11;

  logic               clk;
  logic               rst;
  logic               id_allowin;
  logic               if_id_validto;
  logic [31:0]        pc_out;
  logic [31:0]        instr_out;
  logic [IMEM_AW-1:0] imem_addr;
  logic [31:0]        imem_rdata;
  logic               id_leave;
  logic [2:0]         npc_mux_sel;
  logic [31:0]        id_pc;
  logic [15:0]        id_imm;
  logic [25:0]        id_j_imm;
  logic [31:0]        id_rs;
  logic               cp0_flush;
  logic               eret_flush;
  logic [31:0]        cp0_epc;
  logic               cp0_hlt;
  logic [31:0]        fetch_cnt;
  logic [1:0]         state_o;

  int total = 0;
  int bad   = 0;

  // Reference model state.
  logic [31:0] m_pc;
  logic        m_booted;
  logic        m_halted;
  logic        m_pend;
  logic [31:0] m_pend_pc;
  logic [31:0] m_cnt;

  pipe_if #(.RESET_PC(RESET_PC), .EXC_VECTOR(EXC_VECTOR), .IMEM_AW(IMEM_AW)) dut (
    .clk(clk), .rst(rst), .id_allowin(id_allowin), .if_id_validto(if_id_validto),
    .pc_out(pc_out), .instr_out(instr_out), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .id_leave(id_leave), .npc_mux_sel(npc_mux_sel), .id_pc(id_pc), .id_imm(id_imm),
    .id_j_imm(id_j_imm), .id_rs(id_rs), .cp0_flush(cp0_flush), .eret_flush(eret_flush),
    .cp0_epc(cp0_epc), .cp0_hlt(cp0_hlt), .fetch_cnt(fetch_cnt), .state_o(state_o)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory contents: a distinct word per word address.
  function automatic logic [31:0] mem_word(input logic [IMEM_AW-1:0] a);
    logic [31:0] w;
    w = 32'hC0DE_0000 ^ {21'd0, a} ^ {a, 21'd0};
    return w;
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  // ---------------- checker ----------------
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ---------------- model ----------------
  task automatic model_reset();
    m_pc      = RESET_PC;
    m_booted  = 1'b0;
    m_halted  = 1'b0;
    m_pend    = 1'b0;
    m_pend_pc = 32'd0;
    m_cnt     = 32'd0;
  endtask

  function automatic logic [31:0] calc_target(input logic [2:0] sel);
    int          off;
    logic [31:0] j;
    logic [31:0] t;
    off = $signed(id_imm);
    j   = {6'd0, id_j_imm};
    case (sel)
      3'd1:    t = id_pc + 32'd4 + 32'(off * 4);
      3'd2:    t = ((id_pc + 32'd4) & 32'hF000_0000) + j * 32'd4;
      default: t = id_rs;
    endcase
    return t;
  endfunction

  // ---------------- drivers ----------------
  task automatic idle_inputs();
    id_allowin  = 1'b1;
    id_leave    = 1'b0;
    npc_mux_sel = 3'd0;
    id_pc       = 32'd0;
    id_imm      = 16'd0;
    id_j_imm    = 26'd0;
    id_rs       = 32'd0;
    cp0_flush   = 1'b0;
    eret_flush  = 1'b0;
    cp0_epc     = 32'd0;
    cp0_hlt     = 1'b0;
  endtask

  task automatic rand_inputs();
    id_allowin  = ($urandom_range(0, 3) != 0);
    id_leave    = $urandom_range(0, 1) == 1;
    npc_mux_sel = 3'($urandom_range(0, 3));
    id_pc       = {$urandom} & 32'hFFFF_FFFC;
    id_imm      = 16'($urandom);
    id_j_imm    = 26'($urandom);
    id_rs       = $urandom;
    cp0_flush   = ($urandom_range(0, 24) == 0);
    eret_flush  = ($urandom_range(0, 24) == 0);
    cp0_epc     = {$urandom} & 32'hFFFF_FFFC;
    cp0_hlt     = 1'b0;
  endtask

  // One clock: check outputs against the model mid-cycle, optionally check a
  // directed pc / valid value, then advance the model across the edge.
  task automatic step(input bit pe, input logic [31:0] want_pc, input bit ve, input bit want_v);
    logic        exp_v;
    logic        acc;
    logic        redir;
    logic [31:0] tgt;
    logic [31:0] n_pc;
    logic        n_pend;
    logic [31:0] n_pend_pc;
    logic        n_halted;
    logic [1:0]  exp_state;
    @(negedge clk);
    exp_v     = !rst && m_booted && !m_halted && !cp0_flush && !eret_flush;
    exp_state = !m_booted ? 2'd0 : (m_halted ? 2'd2 : 2'd1);
    chk("valid", {31'd0, if_id_validto}, {31'd0, exp_v});
    chk("pc", pc_out, m_pc);
    chk("instr", instr_out, mem_word(m_pc[IMEM_AW+1:2]));
    chk("addr", {21'd0, imem_addr}, {21'd0, m_pc[IMEM_AW+1:2]});
    chk("cnt", fetch_cnt, m_cnt);
    chk("state", {30'd0, state_o}, {30'd0, exp_state});
    if (pe) chk("dir_pc", pc_out, want_pc);
    if (ve) chk("dir_valid", {31'd0, if_id_validto}, {31'd0, want_v});

    acc       = exp_v && id_allowin;
    redir     = id_leave && (npc_mux_sel >= 3'd1) && (npc_mux_sel <= 3'd3);
    tgt       = calc_target(npc_mux_sel);
    n_pc      = m_pc;
    n_pend    = m_pend;
    n_pend_pc = m_pend_pc;
    n_halted  = m_halted;
    if (!m_halted) begin
      if (cp0_flush) begin
        n_pc = EXC_VECTOR; n_pend = 1'b0;
      end else if (eret_flush) begin
        n_pc = cp0_epc; n_pend = 1'b0;
      end else if (cp0_hlt) begin
        n_halted = 1'b1;
      end else if (acc) begin
        if (redir) begin
          n_pc = tgt; n_pend = 1'b0;
        end else if (m_pend) begin
          n_pc = m_pend_pc; n_pend = 1'b0;
        end else begin
          n_pc = m_pc + 32'd4;
        end
      end else if (redir) begin
        n_pend = 1'b1; n_pend_pc = tgt;
      end
    end
    @(posedge clk);
    #1;
    if (rst) begin
      model_reset();
    end else begin
      m_pc      = n_pc;
      m_pend    = n_pend;
      m_pend_pc = n_pend_pc;
      m_halted  = n_halted;
      m_booted  = 1'b1;
      m_cnt     = m_cnt + (acc ? 32'd1 : 32'd0);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    idle_inputs();
    rst = 1'b1;
    model_reset();
    step(1, RESET_PC, 1, 0);
    step(1, RESET_PC, 1, 0);
    rst = 1'b0;

    // Boot and sequential fetch.
    step(0, 32'd0, 1, 0);
    step(1, 32'h0040_0000, 1, 1);
    step(1, 32'h0040_0004, 1, 1);
    step(1, 32'h0040_0008, 1, 1);
    chk("cnt_after_boot", fetch_cnt, 32'd3);
    step(1, 32'h0040_000C, 1, 1);

    // ID stall holds the offer.
    id_allowin = 1'b0;
    for (int i = 0; i < 3; i++) step(1, 32'h0040_0010, 1, 1);
    chk("cnt_stall", fetch_cnt, 32'd4);
    id_allowin = 1'b1;
    step(1, 32'h0040_0010, 1, 1);
    step(1, 32'h0040_0014, 1, 1);
    step(1, 32'h0040_0018, 1, 1);
    step(1, 32'h0040_001C, 1, 1);
    step(1, 32'h0040_0020, 1, 1);

    // Branch leaving ID alongside the delay-slot accept.
    id_leave = 1'b1; npc_mux_sel = 3'd1; id_pc = 32'h0040_0020; id_imm = 16'hFFFC;
    step(1, 32'h0040_0024, 1, 1);
    idle_inputs();
    step(1, 32'h0040_0014, 1, 1);

    // jr while ID blocks: target parked until the delay slot is taken.
    id_allowin = 1'b0; id_leave = 1'b1; npc_mux_sel = 3'd3; id_rs = 32'h0040_0100;
    step(1, 32'h0040_0018, 1, 1);
    idle_inputs();
    step(1, 32'h0040_0018, 1, 1);
    step(1, 32'h0040_0100, 1, 1);

    // Exception and eret together: exception wins, offer suppressed.
    cp0_flush = 1'b1; eret_flush = 1'b1; cp0_epc = 32'h0040_0200;
    step(1, 32'h0040_0104, 1, 0);
    idle_inputs();
    step(1, 32'h0040_0004, 1, 1);

    // Select values above 3 fetch sequentially.
    id_leave = 1'b1; npc_mux_sel = 3'd5; id_rs = 32'h0040_0300;
    step(1, 32'h0040_0008, 1, 1);
    idle_inputs();
    step(1, 32'h0040_000C, 1, 1);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      rand_inputs();
      step(0, 32'd0, 0, 0);
    end

    // Halt: offer stops and the PC freezes until reset.
    idle_inputs();
    id_allowin = 1'b0; cp0_hlt = 1'b1;
    step(0, 32'd0, 0, 0);
    idle_inputs();
    for (int i = 0; i < 12; i++) begin
      rand_inputs();
      step(0, 32'd0, 1, 0);
    end

    // Reset while halted.
    idle_inputs();
    rst = 1'b1;
    model_reset();
    step(1, RESET_PC, 1, 0);
    chk("rst_cnt", fetch_cnt, 32'd0);
    chk("rst_state", {30'd0, state_o}, 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 40; i++) begin
      rand_inputs();
      step(0, 32'd0, 0, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
